// File: rtl/serial_comparator.sv
// Bit-serial equal/different comparator: consumes WIDTH bit pairs LSB first, then
// reports A==B (select=0) or A!=B (select=1) with a one-cycle out_valid pulse.
module serial_comparator #(
  parameter int WIDTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_start,
  input  logic in_select,
  input  logic in_bit_valid,
  input  logic in_a,
  input  logic in_b,
  output logic out_busy,
  output logic out_valid,
  output logic out_s
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            mismatch;
  logic            select;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      mismatch  <= 1'b0;
      select    <= 1'b0;
      out_busy  <= 1'b0;
      out_valid <= 1'b0;
      out_s     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_start) begin
            select   <= in_select;
            mismatch <= 1'b0;
            count    <= '0;
            state    <= SHIFT;
            out_busy <= 1'b1;
          end
        end
        SHIFT: begin
          // Data inputs only matter when qualified, so X/Z during stalls cannot leak in.
          if (in_bit_valid) begin
            mismatch <= mismatch | (in_a ^ in_b);
            count    <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) state <= DONE;
          end
        end
        DONE: begin
          out_valid <= 1'b1;
          out_s     <= select ? mismatch : ~mismatch;
          state     <= IDLE;
          out_busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          out_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comparator.sv
// Randomized self-checking bench for serial_comparator at WIDTH=2 and WIDTH=8,
// checked against a word-level equality model.
module tb_serial_comparator;

  logic clk = 1'b0;
  logic rst_n;
  logic start, sel, bit_vld, a, b;
  logic tgt;  // 0 drives the WIDTH=2 instance, 1 drives the WIDTH=8 instance

  logic busy2, valid2, s2;
  logic busy8, valid8, s8;
  logic busy, valid, s;

  always #5 clk = ~clk;

  serial_comparator #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_start(start & ~tgt), .in_select(sel), .in_bit_valid(bit_vld & ~tgt),
    .in_a(a), .in_b(b),
    .out_busy(busy2), .out_valid(valid2), .out_s(s2)
  );

  serial_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_start(start & tgt), .in_select(sel), .in_bit_valid(bit_vld & tgt),
    .in_a(a), .in_b(b),
    .out_busy(busy8), .out_valid(valid8), .out_s(s8)
  );

  assign busy  = tgt ? busy8  : busy2;
  assign valid = tgt ? valid8 : valid2;
  assign s     = tgt ? s8     : s2;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses2  = 0;
  int pulses8  = 0;
  int frames2  = 0;
  int frames8  = 0;

  always @(negedge clk) begin
    if (valid2 === 1'b1) pulses2++;
    if (valid8 === 1'b1) pulses8++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full frame on the selected instance. stall<0 picks random stall lengths.
  task automatic run_frame(input int w, input logic [63:0] av, input logic [63:0] bv,
                           input logic sel_in, input int stall, input logic noisy);
    logic [63:0] mask;
    logic        exp_s;
    int          ns;
    mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    exp_s = sel_in ? ((av & mask) != (bv & mask)) : ((av & mask) == (bv & mask));
    tgt   = (w == 8);

    tick();
    start = 1'b1; sel = sel_in;
    bit_vld = 1'($urandom); a = 1'($urandom); b = 1'($urandom);
    @(negedge clk);
    check("idle_busy", busy, 0);

    for (int i = 0; i < w; i++) begin
      ns = (stall < 0) ? $urandom_range(0, 2) : stall;
      if (i == 0) ns = (stall < 0) ? ns : 0;
      for (int k = 0; k < ns; k++) begin
        tick();
        start = noisy; sel = ~sel_in;
        bit_vld = 1'b0; a = 1'($urandom); b = 1'($urandom);
        @(negedge clk);
        check("stall_busy", busy, 1);
        check("stall_valid", valid, 0);
      end
      tick();
      start = noisy; sel = ~sel_in;
      bit_vld = 1'b1; a = av[i]; b = bv[i];
      @(negedge clk);
      check("shift_busy", busy, 1);
      check("shift_valid", valid, 0);
    end

    // DONE cycle: start and bit inputs must be ignored here.
    tick();
    start = noisy; sel = ~sel_in;
    bit_vld = 1'($urandom); a = 1'($urandom); b = 1'($urandom);
    @(negedge clk);
    check("done_busy", busy, 1);
    check("done_valid", valid, 0);

    tick();
    start = 1'b0; bit_vld = 1'b0;
    @(negedge clk);
    check("result_valid", valid, 1);
    check("result_s", s, exp_s);
    check("result_busy", busy, 0);
    if (w == 8) frames8++; else frames2++;

    tick();
    @(negedge clk);
    check("post_valid", valid, 0);
    check("hold_s", s, exp_s);
    check("post_busy", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; bit_vld = 1'b0; a = 1'b0; b = 1'b0; tgt = 1'b0;

    // T1 reset
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy2", busy2, 0);
    check("rst_valid2", valid2, 0);
    check("rst_s2", s2, 0);
    check("rst_busy8", busy8, 0);
    check("rst_valid8", valid8, 0);
    check("rst_s8", s8, 0);

    // T2 exhaustive WIDTH=2, back-to-back frames
    for (int sv = 0; sv < 2; sv++)
      for (int av = 0; av < 4; av++)
        for (int bv = 0; bv < 4; bv++)
          run_frame(2, 64'(av), 64'(bv), 1'(sv), 0, 1'b0);

    // T3 stalls between bits
    run_frame(2, 64'd3, 64'd1, 1'b1, 3, 1'b0);

    // T4 start pulses with opposite select during SHIFT/DONE are ignored
    run_frame(2, 64'd0, 64'd0, 1'b1, 0, 1'b1);
    run_frame(2, 64'd2, 64'd1, 1'b0, 2, 1'b1);

    // T5 reset mid-frame; leave out_s=1 first so the clear is observable
    run_frame(2, 64'd1, 64'd3, 1'b1, 0, 1'b0);
    tgt = 1'b0;
    tick();
    start = 1'b1; sel = 1'b0;
    tick();
    start = 1'b0; bit_vld = 1'b1; a = 1'b1; b = 1'b0;
    tick();
    bit_vld = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("midrst_valid", valid2, 0);
      check("midrst_busy", busy2, 0);
      check("midrst_s", s2, 0);
      tick();
    end
    run_frame(2, 64'd1, 64'd1, 1'b0, 0, 1'b0);

    // T6 WIDTH=8
    run_frame(8, 64'hA5, 64'hA4, 1'b0, 0, 1'b0);
    run_frame(8, 64'hA5, 64'hA5, 1'b0, 1, 1'b0);
    run_frame(8, 64'h80, 64'h00, 1'b1, -1, 1'b1);

    // Randomized frames on both widths
    for (int n = 0; n < 40; n++) begin
      logic [63:0] ra, rb;
      int w;
      w  = (n % 2 == 0) ? 2 : 8;
      ra = 64'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra : 64'($urandom);
      run_frame(w, ra, rb, 1'($urandom), -1, 1'($urandom));
    end

    tick(); tick();
    check("pulse_count2", 64'(pulses2), 64'(frames2));
    check("pulse_count8", 64'(pulses8), 64'(frames8));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
